kamus_mem: RTL and testbench
============================

// Module: kamus_mem
// PURPOSE
//  Memory-access stage directly downstream of kamus_EX. Consumes the EX result (ALU value/effective
//  address) plus load/store control, drives the data-memory req/gnt/rvalid port, aligns/extends load
//  data and delivers a registered writeback record. Non-memory ops pass through with 1-cycle latency.
// PARAMETERS
//  XLEN        32   datapath/address width (only 32 supported)
//  REGADDR_W   5    destination register index width
// PORTS
//  clk_i           in   1      clock
//  rst_i           in   1      asynchronous, active-high reset
//  ex_valid_i      in   1      EX presents an instruction
//  ex_ready_o      out  1      stage can accept (state==IDLE)
//  ex_load_i       in   1      instruction is a load
//  ex_store_i      in   1      instruction is a store
//  ex_funct3_i     in   3      size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_result_i     in   32     EX result; effective address for loads/stores
//  ex_wdata_i      in   32     store data (rs2 value)
//  ex_rd_i         in   5      destination register
//  dmem_req_o      out  1      memory request
//  dmem_we_o       out  1      1=write
//  dmem_be_o       out  4      byte enables
//  dmem_addr_o     out  32     word-aligned address {addr[31:2],2'b00}
//  dmem_wdata_o    out  32     lane-replicated store data
//  dmem_gnt_i      in   1      request accepted
//  dmem_rvalid_i   in   1      read data valid
//  dmem_rdata_i    in   32     read data
//  wb_valid_o      out  1      writeback record valid (1-cycle pulse)
//  wb_we_o         out  1      register write enable
//  wb_rd_o         out  5      destination register
//  wb_data_o       out  32     writeback data
// BEHAVIOUR
//  - Reset: state IDLE; dmem_req_o, dmem_we_o, wb_valid_o, wb_we_o = 0; dmem_be_o, dmem_addr_o,
//    dmem_wdata_o, wb_rd_o, wb_data_o = 0. Reset asserted mid-access aborts it: dmem_req_o falls at once.
//    No wb record is produced; rvalid arriving after reset is ignored.
//  - Accept = ex_valid_i & ex_ready_o; ex_ready_o = (state==IDLE); one instruction in flight max.
//  - FSM: IDLE -accept non-mem-> IDLE (wb next cycle); IDLE -accept ld/st-> REQ; REQ -gnt & store-> IDLE;
//    REQ -gnt & load-> WAIT; WAIT -rvalid-> IDLE. Store wins if ex_load_i & ex_store_i both set.
//  - dmem_* outputs are registered at accept; dmem_req_o held high with stable addr/be/wdata/we until gnt.
//  - Latency (accept at T, gnt same cycle as req): non-mem wb at T+1; store wb at T+2 (wb_we_o=0);
//    load wb at T+1+gnt_wait+rvalid_wait+1, min T+3. wb outputs registered; wb_valid_o high one cycle.
//  - Byte lanes: B be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; H be=addr[1]?1100:0011, wdata={2{wdata[15:0]}};
//    W be=1111. Loads: be=1111, dmem_we_o=0. Funct3 codes not listed above behave as W.
//  - Load extract: byte/half selected by addr offset; B/H sign-extend, BU/HU zero-extend, W unmodified.
//  - wb_we_o = !store & (rd!=0); rd==0 still produces wb_valid_o with wb_we_o=0.
//  - dmem_gnt_i outside REQ and dmem_rvalid_i outside WAIT are ignored.
//  - gnt and rvalid in the same cycle while in REQ: only gnt consumed; rvalid needs WAIT.
// CONFIGURATION
//  KAMUS_MEM_MISALIGN_TRAP_EN defined: adds ports misalign_o (out,1) and misalign_addr_o (out,32).
//    H with addr[0]=1 or W with addr[1:0]!=0 issues no dmem request. wb_valid_o pulses at T+1 with
//    wb_we_o=0; misalign_o pulses in the same cycle, misalign_addr_o = faulting address (0 otherwise).
//  Not defined: ports absent; misaligned low address bits are ignored (H drops addr[0], W drops addr[1:0]).
//    The access proceeds naturally aligned.
// TESTING
//  1. ALU op result=0x1234_5678 rd=5 -> wb_valid@T+1, wb_we=1, wb_data=0x1234_5678, no dmem_req.
//  2. SB addr=0x103 wdata=0xAB, gnt@T+1 -> be=1000, dmem_addr=0x100, dmem_wdata=0xABABABAB, wb_valid@T+2 we=0.
//  3. LB addr=0x202, rdata=0x0080_0000, gnt delayed 2 cycles, rvalid 1 later -> wb_data=0xFFFF_FF80.
//     LBU same -> 0x0000_0080.
//  4. LH addr=0x206 rdata=0x8001_xxxx rd=0 -> wb_data=0xFFFF_8001, wb_we=0. With ex_valid held high,
//     ex_ready_o stays 0 until the cycle after rvalid.
//  5. Assert rst_i while in WAIT, then send rvalid -> req drops immediately, no wb_valid, ex_ready_o=1.
//  6. LW addr=0x301 -> with _EN: no req, misalign_o=1, misalign_addr_o=0x301; without: dmem_addr=0x300, normal load.

Source files
------------

// File: rtl/kamus_mem_if.sv
// rtl/kamus_mem_if.sv - EX-side, data-memory and writeback signal bundle for kamus_mem
interface kamus_mem_if #(
   parameter int XLEN      = 32,
   parameter int REGADDR_W = 5
);
   logic                 ex_valid_i;
   logic                 ex_ready_o;
   logic                 ex_load_i;
   logic                 ex_store_i;
   logic [2:0]           ex_funct3_i;
   logic [XLEN-1:0]      ex_result_i;
   logic [XLEN-1:0]      ex_wdata_i;
   logic [REGADDR_W-1:0] ex_rd_i;

   logic                 dmem_req_o;
   logic                 dmem_we_o;
   logic [3:0]           dmem_be_o;
   logic [XLEN-1:0]      dmem_addr_o;
   logic [XLEN-1:0]      dmem_wdata_o;
   logic                 dmem_gnt_i;
   logic                 dmem_rvalid_i;
   logic [XLEN-1:0]      dmem_rdata_i;

   logic                 wb_valid_o;
   logic                 wb_we_o;
   logic [REGADDR_W-1:0] wb_rd_o;
   logic [XLEN-1:0]      wb_data_o;

   modport master (
      output ex_valid_i, ex_load_i, ex_store_i, ex_funct3_i, ex_result_i, ex_wdata_i, ex_rd_i,
      output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
      input  ex_ready_o, dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
      input  wb_valid_o, wb_we_o, wb_rd_o, wb_data_o
   );

   modport slave (
      input  ex_valid_i, ex_load_i, ex_store_i, ex_funct3_i, ex_result_i, ex_wdata_i, ex_rd_i,
      input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
      output ex_ready_o, dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o, dmem_wdata_o,
      output wb_valid_o, wb_we_o, wb_rd_o, wb_data_o
   );
endinterface

// File: rtl/kamus_mem.sv
// rtl/kamus_mem.sv - memory-access stage: dmem req/gnt/rvalid port, load align/extend, registered writeback
// Optional: KAMUS_MEM_MISALIGN_TRAP_EN adds misalign_o/misalign_addr_o and suppresses misaligned accesses.
module kamus_mem #(
   parameter int XLEN      = 32,
   parameter int REGADDR_W = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   kamus_mem_if.slave           bus
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
   ,
   output logic                 misalign_o,
   output logic [XLEN-1:0]      misalign_addr_o
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

   state_e               state_q, state_d;
   logic                 req_q, req_d;
   logic                 we_q, we_d;
   logic [3:0]           be_q, be_d;
   logic [XLEN-1:0]      addr_q, addr_d;
   logic [XLEN-1:0]      wdata_q, wdata_d;
   logic                 wb_valid_q, wb_valid_d;
   logic                 wb_we_q, wb_we_d;
   logic [REGADDR_W-1:0] wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]      wb_data_q, wb_data_d;
   logic [1:0]           off_q, off_d;
   logic [2:0]           f3_q, f3_d;
   logic [REGADDR_W-1:0] rd_q, rd_d;
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
   logic                 mis_q, mis_d;
   logic [XLEN-1:0]      mis_addr_q, mis_addr_d;
`endif

   function automatic size_e size_of(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: size_of = SZ_B;
         3'b001, 3'b101: size_of = SZ_H;
         default:        size_of = SZ_W;
      endcase
   endfunction

   logic            accept, is_st, is_ld, is_mem, misal;
   size_e           ex_size;
   logic [1:0]      ex_off;
   logic [XLEN-1:0] rd_shift;
   logic [15:0]     rd_half;
   logic [XLEN-1:0] ld_value;

   assign accept  = bus.ex_valid_i && (state_q == S_IDLE);
   assign is_st   = bus.ex_store_i;
   assign is_ld   = bus.ex_load_i && !bus.ex_store_i;
   assign is_mem  = is_st || is_ld;
   assign ex_size = size_of(bus.ex_funct3_i);
   assign ex_off  = bus.ex_result_i[1:0];

`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
   assign misal = is_mem && (((ex_size == SZ_H) && ex_off[0]) || ((ex_size == SZ_W) && (ex_off != 2'b00)));
`else
   assign misal = 1'b0;
`endif

   // Byte extraction ignores off_q[1:0] bits that are meaningless for the access size.
   assign rd_shift = bus.dmem_rdata_i >> {off_q, 3'b000};
   assign rd_half  = off_q[1] ? bus.dmem_rdata_i[31:16] : bus.dmem_rdata_i[15:0];

   always_comb begin
      ld_value = bus.dmem_rdata_i;
      case (f3_q)
         3'b000:  ld_value = {{24{rd_shift[7]}}, rd_shift[7:0]};
         3'b100:  ld_value = {24'h0, rd_shift[7:0]};
         3'b001:  ld_value = {{16{rd_half[15]}}, rd_half};
         3'b101:  ld_value = {16'h0, rd_half};
         default: ld_value = bus.dmem_rdata_i;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      be_d       = be_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      wb_valid_d = 1'b0;
      wb_we_d    = wb_we_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      off_d      = off_q;
      f3_d       = f3_q;
      rd_d       = rd_q;
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
      mis_d      = 1'b0;
      mis_addr_d = '0;
`endif
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (is_mem && !misal) begin
                  state_d = S_REQ;
                  req_d   = 1'b1;
                  we_d    = is_st;
                  addr_d  = {bus.ex_result_i[XLEN-1:2], 2'b00};
                  off_d   = ex_off;
                  f3_d    = bus.ex_funct3_i;
                  rd_d    = bus.ex_rd_i;
                  be_d    = 4'b1111;
                  wdata_d = bus.ex_wdata_i;
                  if (is_st) begin
                     case (ex_size)
                        SZ_B: begin
                           be_d    = 4'b0001 << ex_off;
                           wdata_d = {4{bus.ex_wdata_i[7:0]}};
                        end
                        SZ_H: begin
                           be_d    = ex_off[1] ? 4'b1100 : 4'b0011;
                           wdata_d = {2{bus.ex_wdata_i[15:0]}};
                        end
                        default: be_d = 4'b1111;
                     endcase
                  end
               end else begin
                  wb_valid_d = 1'b1;
                  wb_we_d    = !is_mem && (bus.ex_rd_i != '0);
                  wb_rd_d    = bus.ex_rd_i;
                  wb_data_d  = bus.ex_result_i;
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
                  mis_d      = misal;
                  mis_addr_d = misal ? bus.ex_result_i : '0;
`endif
               end
            end
         end
         S_REQ: begin
            if (bus.dmem_gnt_i) begin
               req_d = 1'b0;
               if (we_q) begin
                  state_d    = S_IDLE;
                  wb_valid_d = 1'b1;
                  wb_we_d    = 1'b0;
                  wb_rd_d    = rd_q;
               end else begin
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (bus.dmem_rvalid_i) begin
               state_d    = S_IDLE;
               wb_valid_d = 1'b1;
               wb_we_d    = (rd_q != '0);
               wb_rd_d    = rd_q;
               wb_data_d  = ld_value;
            end
         end
         default: begin
            state_d = S_IDLE;
            req_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         be_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         wb_valid_q <= 1'b0;
         wb_we_q    <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         off_q      <= '0;
         f3_q       <= '0;
         rd_q       <= '0;
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
         mis_q      <= 1'b0;
         mis_addr_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         be_q       <= be_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         wb_valid_q <= wb_valid_d;
         wb_we_q    <= wb_we_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         off_q      <= off_d;
         f3_q       <= f3_d;
         rd_q       <= rd_d;
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
         mis_q      <= mis_d;
         mis_addr_q <= mis_addr_d;
`endif
      end
   end

   assign bus.ex_ready_o   = (state_q == S_IDLE);
   assign bus.dmem_req_o   = req_q;
   assign bus.dmem_we_o    = we_q;
   assign bus.dmem_be_o    = be_q;
   assign bus.dmem_addr_o  = addr_q;
   assign bus.dmem_wdata_o = wdata_q;
   assign bus.wb_valid_o   = wb_valid_q;
   assign bus.wb_we_o      = wb_we_q;
   assign bus.wb_rd_o      = wb_rd_q;
   assign bus.wb_data_o    = wb_data_q;
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
   assign misalign_o       = mis_q;
   assign misalign_addr_o  = mis_addr_q;
`endif

endmodule

// File: tb/tb_kamus_mem.sv
// tb/tb_kamus_mem.sv - directed and randomized bench for kamus_mem against a memory/word-level model
module tb_kamus_mem;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ncmp = 0;
   int   nfail = 0;
   logic [31:0] mem [0:15];

   always #5 clk = ~clk;

   kamus_mem_if #(.XLEN(32), .REGADDR_W(5)) bif ();

`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
   logic        mis;
   logic [31:0] mis_addr;
   kamus_mem u_dut (.clk_i(clk), .rst_i(rst), .bus(bif), .misalign_o(mis), .misalign_addr_o(mis_addr));
`else
   kamus_mem u_dut (.clk_i(clk), .rst_i(rst), .bus(bif));
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_mis(input string tag, input bit exp_m, input logic [31:0] exp_a);
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
      chk({tag, "_misalign"}, {31'b0, mis}, {31'b0, exp_m});
      chk({tag, "_misaddr"}, mis_addr, exp_a);
`else
      if (exp_m) chk({tag, "_no_misalign_build"}, 32'd1, 32'd0);
      if (exp_a != 32'h0) chk({tag, "_no_misaddr_build"}, exp_a, 32'h0);
`endif
   endtask

   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] load_model(input logic [31:0] word, input logic [2:0] f3, input logic [31:0] addr);
      int sz, v;
      sz = size_of(f3);
      if (sz == 1) begin
         v = int'((word >> (8 * (addr % 4))) & 32'hFF);
         if (f3 == 3'd0 && v >= 128) v = v - 256;
      end else if (sz == 2) begin
         v = int'((word >> (8 * (addr & 32'd2))) & 32'hFFFF);
         if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end else begin
         v = int'(word);
      end
      return 32'(v);
   endfunction

   task automatic run_op(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [4:0] rd, input int gw, input int rw,
                         input bit rv_with_gnt);
      bit          is_mem, exp_mis;
      int          sz, idx;
      logic [3:0]  ebe;
      logic [31:0] ewd, eword, eld;
      is_mem = ld || st;
      sz     = size_of(f3);
      idx    = int'((addr >> 2) & 32'd15);
`ifdef KAMUS_MEM_MISALIGN_TRAP_EN
      exp_mis = is_mem && ((sz == 2 && addr % 2 != 0) || (sz == 4 && addr % 4 != 0));
`else
      exp_mis = 1'b0;
`endif
      eword = addr & ~32'd3;
      ebe = 4'hF;
      ewd = wd;
      if (st && sz == 1) begin
         ebe = 4'(1 << (addr % 4));
         ewd = (wd & 32'hFF) * 32'h01010101;
      end else if (st && sz == 2) begin
         ebe = ((addr & 32'd2) != 0) ? 4'hC : 4'h3;
         ewd = (wd & 32'hFFFF) * 32'h00010001;
      end

      @(negedge clk);
      chk("ready_before_accept", {31'b0, bif.ex_ready_o}, 32'd1);
      bif.ex_valid_i = 1'b1; bif.ex_load_i = ld; bif.ex_store_i = st; bif.ex_funct3_i = f3;
      bif.ex_result_i = addr; bif.ex_wdata_i = wd; bif.ex_rd_i = rd;
      @(posedge clk);
      @(negedge clk);
      bif.ex_result_i = $urandom; bif.ex_wdata_i = $urandom;

      if (!is_mem || exp_mis) begin
         chk("pass_wb_valid", {31'b0, bif.wb_valid_o}, 32'd1);
         chk("pass_wb_we", {31'b0, bif.wb_we_o}, {31'b0, (!is_mem && rd != 0)});
         chk("pass_wb_rd", {27'b0, bif.wb_rd_o}, {27'b0, rd});
         if (!is_mem) chk("pass_wb_data", bif.wb_data_o, addr);
         chk("pass_no_req", {31'b0, bif.dmem_req_o}, 32'd0);
         chk_mis("pass", exp_mis, exp_mis ? addr : 32'h0);
      end else begin
         chk_mis("mem_t1", 1'b0, 32'h0);
         for (int i = 0; i <= gw; i++) begin
            chk("req_high", {31'b0, bif.dmem_req_o}, 32'd1);
            chk("req_addr", bif.dmem_addr_o, eword);
            chk("req_be", {28'b0, bif.dmem_be_o}, {28'b0, ebe});
            chk("req_we", {31'b0, bif.dmem_we_o}, {31'b0, st});
            if (st) chk("req_wdata", bif.dmem_wdata_o, ewd);
            chk("req_no_wb", {31'b0, bif.wb_valid_o}, 32'd0);
            chk("req_not_ready", {31'b0, bif.ex_ready_o}, 32'd0);
            if (i == gw) begin
               bif.dmem_gnt_i = 1'b1;
               bif.dmem_rvalid_i = rv_with_gnt;
               bif.dmem_rdata_i = $urandom;
            end
            @(posedge clk);
            @(negedge clk);
         end
         bif.dmem_gnt_i = 1'b0;
         bif.dmem_rvalid_i = 1'b0;
         chk("req_dropped", {31'b0, bif.dmem_req_o}, 32'd0);
         if (st) begin
            for (int k = 0; k < 4; k++)
               if (ebe[k]) mem[idx][8*k +: 8] = ewd[8*k +: 8];
            chk("st_wb_valid", {31'b0, bif.wb_valid_o}, 32'd1);
            chk("st_wb_we", {31'b0, bif.wb_we_o}, 32'd0);
            chk("st_wb_rd", {27'b0, bif.wb_rd_o}, {27'b0, rd});
         end else begin
            for (int j = 0; j <= rw; j++) begin
               chk("wait_no_wb", {31'b0, bif.wb_valid_o}, 32'd0);
               chk("wait_not_ready", {31'b0, bif.ex_ready_o}, 32'd0);
               if (j == rw) begin
                  bif.dmem_rvalid_i = 1'b1;
                  bif.dmem_rdata_i = mem[idx];
               end
               @(posedge clk);
               @(negedge clk);
            end
            bif.dmem_rvalid_i = 1'b0;
            eld = load_model(mem[idx], f3, addr);
            chk("ld_wb_valid", {31'b0, bif.wb_valid_o}, 32'd1);
            chk("ld_wb_we", {31'b0, bif.wb_we_o}, {31'b0, rd != 0});
            chk("ld_wb_rd", {27'b0, bif.wb_rd_o}, {27'b0, rd});
            chk("ld_wb_data", bif.wb_data_o, eld);
         end
         chk("ready_at_wb", {31'b0, bif.ex_ready_o}, 32'd1);
      end
      bif.ex_valid_i = 1'b0;
      @(negedge clk);
      chk("wb_pulse_ends", {31'b0, bif.wb_valid_o}, 32'd0);
      chk("idle_no_req", {31'b0, bif.dmem_req_o}, 32'd0);
      chk_mis("after", 1'b0, 32'h0);
   endtask

   initial begin
      bif.ex_valid_i = 1'b0; bif.ex_load_i = 1'b0; bif.ex_store_i = 1'b0; bif.ex_funct3_i = 3'd0;
      bif.ex_result_i = '0; bif.ex_wdata_i = '0; bif.ex_rd_i = '0;
      bif.dmem_gnt_i = 1'b0; bif.dmem_rvalid_i = 1'b0; bif.dmem_rdata_i = '0;
      for (int i = 0; i < 16; i++) mem[i] = $urandom;

      repeat (3) @(negedge clk);
      chk("rst_ready", {31'b0, bif.ex_ready_o}, 32'd1);
      chk("rst_req", {31'b0, bif.dmem_req_o}, 32'd0);
      chk("rst_we", {31'b0, bif.dmem_we_o}, 32'd0);
      chk("rst_be", {28'b0, bif.dmem_be_o}, 32'd0);
      chk("rst_addr", bif.dmem_addr_o, 32'd0);
      chk("rst_wdata", bif.dmem_wdata_o, 32'd0);
      chk("rst_wb_valid", {31'b0, bif.wb_valid_o}, 32'd0);
      chk("rst_wb_we", {31'b0, bif.wb_we_o}, 32'd0);
      chk("rst_wb_rd", {27'b0, bif.wb_rd_o}, 32'd0);
      chk("rst_wb_data", bif.wb_data_o, 32'd0);
      rst = 1'b0;

      run_op(0, 0, 3'd0, 32'h1234_5678, 32'h0, 5'd5, 0, 0, 0);
      run_op(0, 1, 3'd0, 32'h0000_0103, 32'h0000_00AB, 5'd7, 0, 0, 0);
      mem[(32'h202 >> 2) & 15] = 32'h0080_0000;
      run_op(1, 0, 3'd0, 32'h0000_0202, 32'h0, 5'd3, 2, 1, 0);
      run_op(1, 0, 3'd4, 32'h0000_0202, 32'h0, 5'd3, 2, 1, 0);
      mem[(32'h206 >> 2) & 15] = 32'h8001_5A5A;
      run_op(1, 0, 3'd1, 32'h0000_0206, 32'h0, 5'd0, 1, 2, 1);
      run_op(1, 1, 3'd2, 32'h0000_0208, 32'hDEAD_BEEF, 5'd9, 0, 0, 0);
      run_op(1, 0, 3'd2, 32'h0000_0301, 32'h0, 5'd4, 0, 0, 0);
      run_op(0, 1, 3'd1, 32'h0000_0107, 32'h0000_C3D2, 5'd8, 1, 0, 0);
      run_op(1, 0, 3'd3, 32'h0000_0104, 32'h0, 5'd6, 0, 0, 0);

      // reset mid-access: once while requesting, once while waiting for rvalid
      for (int phase = 0; phase < 2; phase++) begin
         @(negedge clk);
         bif.ex_valid_i = 1'b1; bif.ex_load_i = 1'b1; bif.ex_store_i = 1'b0; bif.ex_funct3_i = 3'd2;
         bif.ex_result_i = 32'h0000_0110; bif.ex_rd_i = 5'd11;
         @(posedge clk);
         @(negedge clk);
         bif.ex_valid_i = 1'b0;
         if (phase == 1) begin
            bif.dmem_gnt_i = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bif.dmem_gnt_i = 1'b0;
         end
         rst = 1'b1;
         #1;
         chk("rst_mid_req_drop", {31'b0, bif.dmem_req_o}, 32'd0);
         chk("rst_mid_ready", {31'b0, bif.ex_ready_o}, 32'd1);
         @(negedge clk);
         rst = 1'b0;
         bif.dmem_rvalid_i = 1'b1;
         bif.dmem_rdata_i = 32'hCAFE_F00D;
         @(negedge clk);
         bif.dmem_rvalid_i = 1'b0;
         chk("rst_mid_no_wb", {31'b0, bif.wb_valid_o}, 32'd0);
         chk("rst_mid_ready2", {31'b0, bif.ex_ready_o}, 32'd1);
         @(negedge clk);
         chk("rst_mid_no_wb2", {31'b0, bif.wb_valid_o}, 32'd0);
      end

      for (int n = 0; n < 150; n++) begin
         int   kind;
         logic [2:0] f3;
         logic [2:0] ldf [5];
         ldf[0] = 3'd0; ldf[1] = 3'd1; ldf[2] = 3'd2; ldf[3] = 3'd4; ldf[4] = 3'd5;
         kind = int'($urandom_range(0, 2));
         f3 = (kind == 1) ? ldf[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
         run_op(kind == 1, kind == 2, f3, 32'h100 + $urandom_range(0, 63), $urandom,
                5'($urandom_range(0, 31)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
